seg_scan_decoder: RTL and testbench

Multiplexed 7-segment display driver: the decode-side counterpart of the switch-priority encoder that produces a digit code for `seg0`. Holds up to eight 4-bit hex digits written by a simple write port, decodes each to active-low segments, and time-multiplexes them onto one shared segment bus with active-low digit enables. Sits between core/debug logic and the board's segment pins.

---
 rtl/seg_scan_decoder.sv | 125 ++++++++++++
 tb/tb_seg_scan_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
`timescale 1ns/1ps
// seg_scan_decoder
// Multiplexed 7-segment display driver. A simple write port stores up to NDIG
// 4-bit hex digits, each with its own blank flag. The driver decodes each digit
// to active-low segments. It then scans the digits onto one shared segment bus
// and drives active-low digit enables.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset (clears stored digits too)
//   en         display enable; 0 = dark, scan held at digit 0
//   wr_en      write strobe, sampled every rising edge
//   wr_idx     digit to write; indices >= NDIG are ignored
//   wr_data    hex value to store
//   wr_blank   1 = stored digit is blanked
//   an         digit enables, active-low, one-hot-low or all ones
//   seg        segments, active-low, seg[6]=a .. seg[0]=g
//   frame_done one-cycle pulse after the scan wraps back to digit 0
module seg_scan_decoder #(
  parameter int NDIG     = 8,
  parameter int SCAN_DIV = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wr_en,
  input  logic [2:0]      wr_idx,
  input  logic [3:0]      wr_data,
  input  logic            wr_blank,
  output logic [NDIG-1:0] an,
  output logic [6:0]      seg,
  output logic            frame_done
);

  // Degenerate NDIG=1 / SCAN_DIV=1 still get 1-bit counters that simply stay 0.
  localparam int DPW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DPW-1:0] DP_LAST = DPW'(NDIG - 1);
  localparam logic [PCW-1:0] PC_LAST = PCW'(SCAN_DIV - 1);
  localparam logic [6:0]     SEG_OFF = 7'h7F;

  logic [3:0]      digit_val [NDIG];
  logic [NDIG-1:0] digit_blank;
  logic [PCW-1:0]  pc;
  logic [DPW-1:0]  dp;
  logic            tick;
  logic            wr_hit;

  assign tick   = (pc == PC_LAST);
  assign wr_hit = wr_en && (32'(wr_idx) < NDIG);

  // Hex to active-low a..g pattern.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Digit storage. Reset leaves every digit blanked, so the display comes up dark.
  // Out-of-range indices never reach the array because wr_hit filters them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDIG; i++) digit_val[i] <= 4'h0;
      digit_blank <= '1;
    end else if (wr_hit) begin
      digit_val[wr_idx[DPW-1:0]]   <= wr_data;
      digit_blank[wr_idx[DPW-1:0]] <= wr_blank;
    end
  end

  // Prescaler and digit pointer. Dropping en parks the scan at digit 0, so a
  // re-enable always starts a fresh frame. frame_done is registered alongside
  // the wrap of dp, so it is high during the first cycle of the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      dp         <= '0;
      frame_done <= 1'b0;
    end else if (!en) begin
      pc         <= '0;
      dp         <= '0;
      frame_done <= 1'b0;
    end else if (tick) begin
      pc         <= '0;
      dp         <= (dp == DP_LAST) ? '0 : dp + DPW'(1);
      frame_done <= (dp == DP_LAST);
    end else begin
      pc         <= pc + PCW'(1);
      frame_done <= 1'b0;
    end
  end

  // Output register. The register computes an and seg from the same pre-edge dp.
  // Both outputs therefore switch together and no digit shows a neighbour's pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_OFF;
    end else if (!en) begin
      an  <= '1;
      seg <= SEG_OFF;
    end else begin
      an  <= ~(NDIG'(1) << dp);
      seg <= digit_blank[dp] ? SEG_OFF : decode(digit_val[dp]);
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
`timescale 1ns/1ps
// Testbench for seg_scan_decoder. It uses three instances that share one set of
// inputs: an 8-digit fast-scan display, a 1-digit display that scans every cycle,
// and a 4-digit display used to check that out-of-range writes are ignored.
module tb_seg_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [3:0] wr_data;
  logic       wr_blank;

  logic [7:0] an8;
  logic [6:0] seg8;
  logic       fd8;
  logic [0:0] an1;
  logic [6:0] seg1;
  logic       fd1;
  logic [3:0] an4;
  logic [6:0] seg4;
  logic       fd4;

  int n_cmp = 0;
  int n_err = 0;

  // Active-low a..g patterns, typed in by hand from the segment table.
  logic [6:0] dec_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg_scan_decoder #(.NDIG(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .wr_blank(wr_blank), .an(an8), .seg(seg8), .frame_done(fd8)
  );

  seg_scan_decoder #(.NDIG(1), .SCAN_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .wr_blank(wr_blank), .an(an1), .seg(seg1), .frame_done(fd1)
  );

  seg_scan_decoder #(.NDIG(4), .SCAN_DIV(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .wr_blank(wr_blank), .an(an4), .seg(seg4), .frame_done(fd4)
  );

  always #5 clk = ~clk;

  // Advance one clock and land on the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One-cycle write, driven from a falling edge. Returns at the falling edge just
  // after the edge that sampled it, with wr_en low again.
  task automatic applyStimulus(input logic [2:0] idx, input logic [3:0] data,
                               input logic blank);
    wr_en    = 1'b1;
    wr_idx   = idx;
    wr_data  = data;
    wr_blank = blank;
    step();
    wr_en = 1'b0;
  endtask

  // Bounded wait for the 8-digit scan to reach a given enable pattern.
  task automatic wait_an8(input logic [7:0] target, input string name);
    for (int i = 0; i < 80 && an8 !== target; i++) @(negedge clk);
    n_cmp++;
    if (an8 !== target) begin
      n_err++;
      $display("[TB] FAIL %s: an=%h want %h (timeout)", name, an8, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; wr_en = 1'b0; wr_idx = 3'd0; wr_data = 4'h0; wr_blank = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (an8 !== 8'hFF) begin n_err++; $display("[TB] FAIL reset_an: got %h want ff", an8); end
    n_cmp++; if (seg8 !== 7'h7F) begin n_err++; $display("[TB] FAIL reset_seg: got %h want 7f", seg8); end
    n_cmp++; if (fd8 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_fd: got %b want 0", fd8); end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] exp_an;
      step();
      exp_an = ~(8'd1 << (k / 4));
      n_cmp++; if (an8 !== exp_an) begin n_err++; $display("[TB] FAIL reset_scan_an k=%0d: got %h want %h", k, an8, exp_an); end
      n_cmp++; if (seg8 !== 7'h7F) begin n_err++; $display("[TB] FAIL reset_blank_seg k=%0d: got %h want 7f", k, seg8); end
    end
  endtask

  task automatic test_decode_sweep();
    for (int v = 0; v < 16; v++) begin
      applyStimulus(3'd0, 4'(v), 1'b0);
      step();
      n_cmp++; if (seg1 !== dec_tab[v]) begin n_err++; $display("[TB] FAIL decode_%h: got %b want %b", v, seg1, dec_tab[v]); end
      n_cmp++; if (an1 !== 1'b0) begin n_err++; $display("[TB] FAIL decode_an_%h: got %b want 0", v, an1); end
      n_cmp++; if (fd1 !== 1'b1) begin n_err++; $display("[TB] FAIL ndig1_fd_%h: got %b want 1", v, fd1); end
    end
  endtask

  task automatic test_scan_order();
    en = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(3'(i), 4'(i), 1'b0);
    n_cmp++; if (an8 !== 8'hFF) begin n_err++; $display("[TB] FAIL scan_off_an: got %h want ff", an8); end
    n_cmp++; if (seg8 !== 7'h7F) begin n_err++; $display("[TB] FAIL scan_off_seg: got %h want 7f", seg8); end
    en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      logic [7:0] exp_an;
      int d;
      step();
      d = (k / 4) % 8;
      exp_an = ~(8'd1 << d);
      n_cmp++; if (an8 !== exp_an) begin n_err++; $display("[TB] FAIL scan_an k=%0d: got %h want %h", k, an8, exp_an); end
      n_cmp++; if (seg8 !== dec_tab[d]) begin n_err++; $display("[TB] FAIL scan_seg k=%0d: got %b want %b", k, seg8, dec_tab[d]); end
      n_cmp++; if (fd8 !== (k % 32 == 31)) begin n_err++; $display("[TB] FAIL scan_fd k=%0d: got %b want %b", k, fd8, (k % 32 == 31)); end
    end
  endtask

  task automatic test_blank_bad_index();
    applyStimulus(3'd3, 4'h9, 1'b1);
    wait_an8(8'hF7, "blank_wait");
    n_cmp++; if (seg8 !== 7'h7F) begin n_err++; $display("[TB] FAIL blank_seg: got %h want 7f", seg8); end
    // Index 5 is out of range for the 4- and 1-digit instances.
    applyStimulus(3'd5, 4'hF, 1'b0);
    for (int k = 0; k < 8; k++) begin
      logic [6:0] exp_seg;
      step();
      case (an4)
        4'hE: exp_seg = dec_tab[0];
        4'hD: exp_seg = dec_tab[1];
        4'hB: exp_seg = dec_tab[2];
        4'h7: exp_seg = 7'h7F;
        default: exp_seg = 7'hxx;
      endcase
      n_cmp++; if (seg4 !== exp_seg) begin n_err++; $display("[TB] FAIL badidx_seg4 an=%h: got %b want %b", an4, seg4, exp_seg); end
    end
    n_cmp++; if (seg1 !== dec_tab[0]) begin n_err++; $display("[TB] FAIL badidx_seg1: got %b want %b", seg1, dec_tab[0]); end
  endtask

  task automatic test_live_update();
    wait_an8(8'hFD, "live_wait_fd");
    wait_an8(8'hFB, "live_wait_fb");
    applyStimulus(3'd2, 4'hE, 1'b0);
    n_cmp++; if (seg8 !== dec_tab[2]) begin n_err++; $display("[TB] FAIL live_old_seg: got %b want %b", seg8, dec_tab[2]); end
    n_cmp++; if (an8 !== 8'hFB) begin n_err++; $display("[TB] FAIL live_old_an: got %h want fb", an8); end
    step();
    n_cmp++; if (seg8 !== 7'b0110000) begin n_err++; $display("[TB] FAIL live_new_seg: got %b want 0110000", seg8); end
    n_cmp++; if (an8 !== 8'hFB) begin n_err++; $display("[TB] FAIL live_new_an: got %h want fb", an8); end
  endtask

  task automatic test_enable_midscan();
    wait_an8(8'hDF, "en_wait_d5");
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++; if (an8 !== 8'hFF) begin n_err++; $display("[TB] FAIL en_off_an k=%0d: got %h want ff", k, an8); end
      n_cmp++; if (seg8 !== 7'h7F) begin n_err++; $display("[TB] FAIL en_off_seg k=%0d: got %h want 7f", k, seg8); end
      n_cmp++; if (fd8 !== 1'b0) begin n_err++; $display("[TB] FAIL en_off_fd k=%0d: got %b want 0", k, fd8); end
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (an8 !== 8'hFE) begin n_err++; $display("[TB] FAIL en_on_an k=%0d: got %h want fe", k, an8); end
      n_cmp++; if (seg8 !== dec_tab[0]) begin n_err++; $display("[TB] FAIL en_on_seg k=%0d: got %b want %b", k, seg8, dec_tab[0]); end
    end
    step();
    n_cmp++; if (an8 !== 8'hFD) begin n_err++; $display("[TB] FAIL en_on_next_an: got %h want fd", an8); end
    n_cmp++; if (seg8 !== dec_tab[1]) begin n_err++; $display("[TB] FAIL en_on_next_seg: got %b want %b", seg8, dec_tab[1]); end
  endtask

  task automatic test_reset_midframe();
    rst = 1'b1;
    #1;
    n_cmp++; if (an8 !== 8'hFF) begin n_err++; $display("[TB] FAIL midrst_an: got %h want ff", an8); end
    n_cmp++; if (seg8 !== 7'h7F) begin n_err++; $display("[TB] FAIL midrst_seg: got %h want 7f", seg8); end
    n_cmp++; if (fd8 !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_fd: got %b want 0", fd8); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] exp_an;
      step();
      exp_an = ~(8'd1 << (k / 4));
      n_cmp++; if (an8 !== exp_an) begin n_err++; $display("[TB] FAIL midrst_scan_an k=%0d: got %h want %h", k, an8, exp_an); end
      n_cmp++; if (seg8 !== 7'h7F) begin n_err++; $display("[TB] FAIL midrst_cleared_seg k=%0d: got %h want 7f", k, seg8); end
    end
    n_cmp++; if (seg1 !== 7'h7F) begin n_err++; $display("[TB] FAIL midrst_seg1: got %h want 7f", seg1); end
    n_cmp++; if (seg4 !== 7'h7F) begin n_err++; $display("[TB] FAIL midrst_seg4: got %h want 7f", seg4); end
  endtask

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Run the scenarios in order, then print the summary.
  initial begin
    test_reset();
    test_decode_sweep();
    test_scan_order();
    test_blank_bad_index();
    test_live_update();
    test_enable_midscan();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
